// File: rtl/rana_pkg.sv
// rana_pkg: shared direction encoding and index helpers for the frog (RANA)
// lane/column position logic.
package rana_pkg;

  // Move direction encoding.
  localparam logic [1:0] DIR_NONE  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  // Widest one-hot vector the helpers can build; callers size-cast down.
  localparam int MAX_WIDTH = 64;

  // One-hot of idx within a width-bit vector; index 0 maps to the MSB.
  // An out-of-range idx yields all zeros.
  function automatic logic [MAX_WIDTH-1:0] idx_to_onehot(input int unsigned idx,
                                                          input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    if (idx < width) begin
      v = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1 - idx);
    end
    return v;
  endfunction

  // Index one step in dir; at an edge either wraps or holds the index.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input logic [1:0]  dir,
                                           input logic        wrap,
                                           input int unsigned width);
    int unsigned n;
    n = idx;
    case (dir)
      DIR_LEFT: begin
        if (idx == 0) n = wrap ? (width - 1) : idx;
        else          n = idx - 1;
      end
      DIR_RIGHT: begin
        if (idx >= width - 1) n = wrap ? 0 : idx;
        else                  n = idx + 1;
      end
      default: n = idx;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/onehot_pos_cooldown.sv
// onehot_pos_cooldown: move cool-down timer. A down-counter loaded with
// COOLDOWN on an accepted move, cleared by a load, decrementing to zero.
// o_ready is registered and always equals (counter == 0).
module onehot_pos_cooldown
  import rana_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int COOLDOWN  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_ready
);

  localparam logic [CNT_WIDTH-1:0] LP_LOAD_VAL = CNT_WIDTH'(COOLDOWN);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_ready;

  // Next counter value: clear wins over load, otherwise count down to zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear) begin
      w_cnt_next = '0;
    end else if (i_load) begin
      w_cnt_next = LP_LOAD_VAL;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  // Counter and ready flag; ready is computed from the next count so the
  // registered flag tracks the counter in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_next;
      r_ready <= (w_cnt_next == '0);
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/onehot_pos_decoder.sv
// onehot_pos_decoder: registered binary-index to one-hot position register
// for the frog (RANA) column select. Steps left/right with wrap or saturate,
// enforces a move cool-down, and accepts direct loads.
// Optional feature: define ONEHOT_POS_BLOCK_EN to add ONEHOT_POS_Blocked_In,
// which refuses moves onto blocked positions.
module onehot_pos_decoder
  import rana_pkg::*;
#(
  parameter int SEL_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_POS  = 0,
  parameter int COOLDOWN   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  ONEHOT_POS_CLOCK_50,
  input  logic                  ONEHOT_POS_RESET_InLow,
  input  logic                  ONEHOT_POS_Load_In,
  input  logic [SEL_WIDTH-1:0]  ONEHOT_POS_LoadIdx_In,
  input  logic                  ONEHOT_POS_Left_In,
  input  logic                  ONEHOT_POS_Right_In,
  input  logic                  ONEHOT_POS_Wrap_In,
`ifdef ONEHOT_POS_BLOCK_EN
  input  logic [DATA_WIDTH-1:0] ONEHOT_POS_Blocked_In,
`endif
  output logic [DATA_WIDTH-1:0] ONEHOT_POS_Data_Out,
  output logic [SEL_WIDTH-1:0]  ONEHOT_POS_Index_Out,
  output logic                  ONEHOT_POS_Ready_Out,
  output logic                  ONEHOT_POS_Moved_Out,
  output logic                  ONEHOT_POS_Bump_Out,
  output logic                  ONEHOT_POS_Error_Out
);

  // One extra bit so DATA_WIDTH itself is representable when it equals
  // 2**SEL_WIDTH.
  localparam int IDXW = SEL_WIDTH + 1;

  localparam logic [SEL_WIDTH-1:0]  LP_RESET_IDX = SEL_WIDTH'(RESET_POS);
  localparam logic [DATA_WIDTH-1:0] LP_RESET_OH  =
    DATA_WIDTH'(idx_to_onehot(RESET_POS, DATA_WIDTH));
  localparam logic [IDXW-1:0]       LP_LAST_IDX  = IDXW'(DATA_WIDTH - 1);
  localparam logic [IDXW-1:0]       LP_NUM_POS   = IDXW'(DATA_WIDTH);

  logic [SEL_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_moved;
  logic                  r_bump;
  logic                  r_error;

  logic [IDXW-1:0]       w_idx_ext;
  logic [IDXW-1:0]       w_load_ext;
  logic [IDXW-1:0]       w_target_ext;
  logic [DATA_WIDTH-1:0] w_target_oh;
  logic [DATA_WIDTH-1:0] w_next_oh;
  logic [SEL_WIDTH-1:0]  w_next_idx;
  logic [1:0]            w_dir;
  logic                  w_load_ok;
  logic                  w_at_edge;
  logic                  w_blocked;
  logic                  w_ready;
  logic                  w_moved;
  logic                  w_bump;
  logic                  w_error;
  logic                  w_cd_load;
  logic                  w_cd_clear;

  assign w_idx_ext  = {1'b0, r_index};
  assign w_load_ext = {1'b0, ONEHOT_POS_LoadIdx_In};
  assign w_load_ok  = (w_load_ext < LP_NUM_POS);

  // Resolve the requested direction; both or neither means no move.
  always_comb begin
    w_dir = DIR_NONE;
    if (ONEHOT_POS_Left_In && !ONEHOT_POS_Right_In) begin
      w_dir = DIR_LEFT;
    end else if (ONEHOT_POS_Right_In && !ONEHOT_POS_Left_In) begin
      w_dir = DIR_RIGHT;
    end
  end

  assign w_at_edge = ((w_dir == DIR_LEFT)  && (w_idx_ext == '0)) ||
                     ((w_dir == DIR_RIGHT) && (w_idx_ext == LP_LAST_IDX));

  assign w_target_ext = IDXW'(next_idx(32'(w_idx_ext), w_dir,
                                       ONEHOT_POS_Wrap_In, DATA_WIDTH));
  assign w_target_oh  = DATA_WIDTH'(idx_to_onehot(32'(w_target_ext), DATA_WIDTH));

`ifdef ONEHOT_POS_BLOCK_EN
  assign w_blocked = |(w_target_oh & ONEHOT_POS_Blocked_In);
`else
  assign w_blocked = 1'b0;
`endif

  // Per-cycle command priority: load, rejected load, conflicting move,
  // accepted move (or bump), otherwise hold.
  always_comb begin
    w_next_idx = r_index;
    w_moved    = 1'b0;
    w_bump     = 1'b0;
    w_error    = 1'b0;
    w_cd_load  = 1'b0;
    w_cd_clear = 1'b0;
    if (ONEHOT_POS_Load_In) begin
      if (w_load_ok) begin
        w_next_idx = ONEHOT_POS_LoadIdx_In;
        w_moved    = 1'b1;
        w_cd_clear = 1'b1;
      end else begin
        w_error    = 1'b1;
      end
    end else if (w_dir != DIR_NONE && w_ready) begin
      if (w_at_edge && !ONEHOT_POS_Wrap_In) begin
        w_bump = 1'b1;
      end else if (w_blocked) begin
        w_bump = 1'b1;
      end else begin
        w_next_idx = w_target_ext[SEL_WIDTH-1:0];
        w_moved    = 1'b1;
        w_cd_load  = 1'b1;
      end
    end
  end

  assign w_next_oh = DATA_WIDTH'(idx_to_onehot(32'(w_next_idx), DATA_WIDTH));

  // Position and pulse registers; one-hot and index are updated together so
  // they can never disagree.
  always_ff @(posedge ONEHOT_POS_CLOCK_50 or negedge ONEHOT_POS_RESET_InLow) begin
    if (!ONEHOT_POS_RESET_InLow) begin
      r_index <= LP_RESET_IDX;
      r_data  <= LP_RESET_OH;
      r_moved <= 1'b0;
      r_bump  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_index <= w_next_idx;
      r_data  <= w_next_oh;
      r_moved <= w_moved;
      r_bump  <= w_bump;
      r_error <= w_error;
    end
  end

  onehot_pos_cooldown #(
    .CNT_WIDTH (CNT_WIDTH),
    .COOLDOWN  (COOLDOWN)
  ) u_cooldown (
    .i_clk   (ONEHOT_POS_CLOCK_50),
    .i_rst_n (ONEHOT_POS_RESET_InLow),
    .i_load  (w_cd_load),
    .i_clear (w_cd_clear),
    .o_ready (w_ready)
  );

  assign ONEHOT_POS_Data_Out  = r_data;
  assign ONEHOT_POS_Index_Out = r_index;
  assign ONEHOT_POS_Ready_Out = w_ready;
  assign ONEHOT_POS_Moved_Out = r_moved;
  assign ONEHOT_POS_Bump_Out  = r_bump;
  assign ONEHOT_POS_Error_Out = r_error;

endmodule
